// File: rtl/feature_transfer_if.sv
// Feature-transfer bus: pipeline write side, frame publication and CPU read port.
interface feature_transfer_if #(
  parameter int unsigned FEATURE_WIDTH = 32,
  parameter int unsigned ADDRESS_WIDTH = 8
);
  logic                     featureValid;
  logic [FEATURE_WIDTH-1:0] featureData;
  logic                     frameEnd;
  logic                     dataReady;
  logic [31:0]              numberOfFeatures;
  logic                     frameOverflow;
  logic [ADDRESS_WIDTH-1:0] readAddress;
  logic [FEATURE_WIDTH-1:0] readData;

  modport master (
    output featureValid, featureData, frameEnd, readAddress,
    input  dataReady, numberOfFeatures, frameOverflow, readData
  );

  modport slave (
    input  featureValid, featureData, frameEnd, readAddress,
    output dataReady, numberOfFeatures, frameOverflow, readData
  );
endinterface

// File: rtl/feature_transfer.sv
// Ping-pong feature buffer: collects one frame of records while the CPU reads the
// previously published frame; swaps banks and pulses dataReady at each frame end.
module feature_transfer #(
  parameter int unsigned FEATURE_WIDTH = 32,
  parameter int unsigned MAX_FEATURES  = 256,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input logic                 clock,
  input logic                 reset,
  feature_transfer_if.slave   bus
);

  localparam int unsigned CW    = ADDRESS_WIDTH + 1;
  localparam int unsigned DEPTH = 2 * MAX_FEATURES;

  logic [FEATURE_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]            count_q, count_d;
  logic                     pend_q, pend_d;
  logic                     write_bank_q, write_bank_d;
  logic                     read_bank_q, read_bank_d;
  logic                     ready_q, ready_d;
  logic [31:0]              num_q, num_d;
  logic                     ovf_q, ovf_d;
  logic [FEATURE_WIDTH-1:0] rdata_q, rdata_d;

  logic                     room;
  logic                     wr_en;
  logic [CW-1:0]            count_inc;
  logic                     pend_inc;
  logic [ADDRESS_WIDTH-1:0] wr_index;

  // Write-side bookkeeping and frame publication.
  always_comb begin
    room      = (count_q < CW'(MAX_FEATURES));
    wr_en     = bus.featureValid & room;
    count_inc = count_q + CW'(wr_en);
    pend_inc  = pend_q | (bus.featureValid & ~room);
    wr_index  = count_q[ADDRESS_WIDTH-1:0];

    count_d      = count_inc;
    pend_d       = pend_inc;
    write_bank_d = write_bank_q;
    read_bank_d  = read_bank_q;
    ready_d      = 1'b0;
    num_d        = num_q;
    ovf_d        = ovf_q;

    if (bus.frameEnd) begin
      count_d      = '0;
      pend_d       = 1'b0;
      write_bank_d = ~write_bank_q;
      read_bank_d  = ~read_bank_q;
      ready_d      = 1'b1;
      num_d        = 32'(count_inc);
      ovf_d        = pend_inc;
    end
  end

  // Reads follow the post-edge bank/count so a read at the swap edge sees the new
  // frame; the record written at that same edge is forwarded past the RAM.
  always_comb begin
    rdata_d = '0;
    if (32'(bus.readAddress) < num_d) begin
      if (wr_en && (write_bank_q == read_bank_d) && (wr_index == bus.readAddress)) begin
        rdata_d = bus.featureData;
      end else begin
        rdata_d = mem[{read_bank_d, bus.readAddress}];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      pend_q       <= 1'b0;
      write_bank_q <= 1'b0;
      read_bank_q  <= 1'b1;
      ready_q      <= 1'b0;
      num_q        <= '0;
      ovf_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      count_q      <= count_d;
      pend_q       <= pend_d;
      write_bank_q <= write_bank_d;
      read_bank_q  <= read_bank_d;
      ready_q      <= ready_d;
      num_q        <= num_d;
      ovf_q        <= ovf_d;
      rdata_q      <= rdata_d;
    end
  end

  // Record storage; contents intentionally survive reset.
  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem[{write_bank_q, wr_index}] <= bus.featureData;
    end
  end

  assign bus.dataReady        = ready_q;
  assign bus.numberOfFeatures = num_q;
  assign bus.frameOverflow    = ovf_q;
  assign bus.readData         = rdata_q;

endmodule

// File: tb/tb_feature_transfer.sv
// Directed bench for feature_transfer: publication, read-back, overflow and reset.
module tb_feature_transfer;

  localparam int unsigned FW = 32;
  localparam int unsigned MF = 256;
  localparam int unsigned AW = 8;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  feature_transfer_if #(.FEATURE_WIDTH(FW), .ADDRESS_WIDTH(AW)) bus ();

  feature_transfer #(
    .FEATURE_WIDTH(FW),
    .MAX_FEATURES (MF),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Streams n records base+i; optionally raises frameEnd with the last one.
  task automatic send(input int n, input logic [31:0] base, input bit end_with_last);
    for (int i = 0; i < n; i++) begin
      bus.featureValid = 1'b1;
      bus.featureData  = base + 32'(i);
      bus.frameEnd     = end_with_last && (i == n - 1);
      tick();
    end
    bus.featureValid = 1'b0;
    bus.frameEnd     = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
    bus.readAddress = AW'(addr);
    tick();
    check(tag, bus.readData, exp);
  endtask

  initial begin
    reset            = 1'b1;
    bus.featureValid = 1'b0;
    bus.featureData  = '0;
    bus.frameEnd     = 1'b0;
    bus.readAddress  = '0;
    tick();
    tick();
    check("rst_ready", 32'(bus.dataReady), 32'd0);
    check("rst_num",   bus.numberOfFeatures, 32'd0);
    check("rst_ovf",   32'(bus.frameOverflow), 32'd0);
    check("rst_rdata", bus.readData, 32'd0);
    reset = 1'b0;

    // Frame 1: 12 records, separate frameEnd
    send(12, 32'h100, 1'b0);
    check("f1_no_pulse", 32'(bus.dataReady), 32'd0);
    bus.frameEnd = 1'b1;
    tick();
    bus.frameEnd = 1'b0;
    check("f1_ready", 32'(bus.dataReady), 32'd1);
    check("f1_num",   bus.numberOfFeatures, 32'd12);
    check("f1_ovf",   32'(bus.frameOverflow), 32'd0);
    tick();
    check("f1_ready_drop", 32'(bus.dataReady), 32'd0);
    check("f1_num_hold",   bus.numberOfFeatures, 32'd12);
    for (int a = 0; a < 12; a++) read_check("f1_read", a, 32'h100 + 32'(a));
    read_check("f1_read_end", 12, 32'd0);

    // Frame 2: 22 records, last coincides with frameEnd; read issued at swap edge
    send(21, 32'h200, 1'b0);
    bus.featureValid = 1'b1;
    bus.featureData  = 32'h215;
    bus.frameEnd     = 1'b1;
    bus.readAddress  = AW'(21);
    tick();
    bus.featureValid = 1'b0;
    bus.frameEnd     = 1'b0;
    check("f2_ready",      32'(bus.dataReady), 32'd1);
    check("f2_num",        bus.numberOfFeatures, 32'd22);
    check("f2_swap_read",  bus.readData, 32'h215);
    read_check("f2_read0",  0, 32'h200);
    read_check("f2_read11", 11, 32'h20B);
    read_check("f2_read21", 21, 32'h215);
    read_check("f2_read22", 22, 32'd0);

    // Empty frame, then two back-to-back frameEnds
    bus.frameEnd = 1'b1;
    tick();
    check("e0_ready", 32'(bus.dataReady), 32'd1);
    check("e0_num",   bus.numberOfFeatures, 32'd0);
    check("e0_ovf",   32'(bus.frameOverflow), 32'd0);
    bus.frameEnd = 1'b0;
    read_check("e0_read0", 0, 32'd0);
    check("e0_ready_drop", 32'(bus.dataReady), 32'd0);
    bus.frameEnd = 1'b1;
    tick();
    check("b2b_ready1", 32'(bus.dataReady), 32'd1);
    check("b2b_num1",   bus.numberOfFeatures, 32'd0);
    tick();
    bus.frameEnd = 1'b0;
    check("b2b_ready2", 32'(bus.dataReady), 32'd1);
    check("b2b_num2",   bus.numberOfFeatures, 32'd0);
    tick();
    check("b2b_ready_drop", 32'(bus.dataReady), 32'd0);

    // Overflow frame: 260 records saturate at 256
    send(260, 32'h1000, 1'b0);
    check("ov_no_pulse", 32'(bus.dataReady), 32'd0);
    bus.frameEnd = 1'b1;
    tick();
    bus.frameEnd = 1'b0;
    check("ov_ready", 32'(bus.dataReady), 32'd1);
    check("ov_num",   bus.numberOfFeatures, 32'd256);
    check("ov_ovf",   32'(bus.frameOverflow), 32'd1);
    read_check("ov_read0",   0,   32'h1000);
    read_check("ov_read255", 255, 32'h10FF);
    check("ov_ovf_hold", 32'(bus.frameOverflow), 32'd1);

    // Following frame clears overflow
    send(32, 32'h3000, 1'b1);
    check("nx_ready", 32'(bus.dataReady), 32'd1);
    check("nx_num",   bus.numberOfFeatures, 32'd32);
    check("nx_ovf",   32'(bus.frameOverflow), 32'd0);
    read_check("nx_read31", 31, 32'h301F);
    read_check("nx_read32", 32, 32'd0);

    // Reset mid-frame discards the partial frame
    send(5, 32'h400, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_ready", 32'(bus.dataReady), 32'd0);
    check("mr_num",   bus.numberOfFeatures, 32'd0);
    check("mr_ovf",   32'(bus.frameOverflow), 32'd0);
    check("mr_rdata", bus.readData, 32'd0);
    send(3, 32'h500, 1'b0);
    check("mr_no_pulse", 32'(bus.dataReady), 32'd0);
    bus.frameEnd = 1'b1;
    tick();
    bus.frameEnd = 1'b0;
    check("mr_pub_ready", 32'(bus.dataReady), 32'd1);
    check("mr_pub_num",   bus.numberOfFeatures, 32'd3);
    read_check("mr_read0", 0, 32'h500);
    read_check("mr_read2", 2, 32'h502);
    read_check("mr_read3", 3, 32'd0);

    // Post-reset bank 0 was just published, so the next frame fills bank 1
    send(2, 32'h600, 1'b1);
    check("mr_next_num", bus.numberOfFeatures, 32'd2);
    read_check("mr_next_read1", 1, 32'h601);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/feature_transfer.md
Name: feature_transfer

Overview:
- Upstream neighbour of waitForTransfer.
- Collects per-frame feature records (blob descriptors) from the detection pipeline into a ping-pong buffer.
- At end of frame: swaps banks, publishes the frame's feature count, and pulses dataReady for one cycle. waitForTransfer consumes these via its dataReady/numberOfFeatures inputs.
- The CPU then reads the completed bank through a synchronous read port.

Parameters:
- FEATURE_WIDTH, 32, bits per feature record.
- MAX_FEATURES, 256, capacity of each bank in records; power of two.
- ADDRESS_WIDTH, 8, log2(MAX_FEATURES).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- featureValid  input  1  featureData carries a record this cycle.
- featureData  input  FEATURE_WIDTH  feature record.
- frameEnd  input  1  single-cycle marker closing the current frame.
- dataReady  output  1  one-cycle pulse: a frame was published.
- numberOfFeatures  output  32  record count of the last published frame.
- frameOverflow  output  1  last published frame dropped records.
- readAddress  input  ADDRESS_WIDTH  CPU read index into the published bank.
- readData  output  FEATURE_WIDTH  record at readAddress, one-cycle latency.

Behaviour:
- One clock. reset is synchronous and active-high; sampled on the rising edge of clock.
- Reset values:
  - dataReady=0, numberOfFeatures=0, frameOverflow=0, readData=0.
  - writeBank=0, readBank=1, write count=0, overflow-pending=0.
  - RAM contents are not cleared.
- Write path:
  - featureValid sampled high with count<MAX_FEATURES: store at bank[writeBank][count], count+1.
  - featureValid with count==MAX_FEATURES: record dropped, overflow-pending set; count holds (saturates).
- Frame close (frameEnd sampled high at edge N):
  - A feature sampled at edge N belongs to the closing frame; it is included in the count if there is room.
  - Edge N+1: dataReady=1 for exactly one cycle.
  - numberOfFeatures = final count, zero-extended to 32 bits.
  - frameOverflow = final overflow-pending.
  - readBank/writeBank swap. count and overflow-pending restart at 0 for the new frame.
- numberOfFeatures and frameOverflow hold until the next publication. They stay stable while dataReady is low.
- Empty frame: frameEnd with no features publishes numberOfFeatures=0 with a dataReady pulse.
- frameEnd on consecutive cycles: one pulse per frameEnd; the second reports 0 (or only the features sampled at that second edge).
- Read path:
  - readData registered from bank[readBank][readAddress]; valid the cycle after readAddress is presented.
  - If readAddress >= numberOfFeatures at sample time, readData=0.
  - The read always uses the readBank value at the sampling edge. A read issued at the swap edge returns the newly published bank.
- CPU contract: reads of a published frame must complete before the next frameEnd. The bank is overwritten one frame later; no lock or handshake back-pressures the pipeline.
- Reset mid-frame: partial frame discarded, no dataReady pulse, banks return to reset selection.
- No backpressure: featureValid is never stalled.

Test Plan:
- Reset, then 12 featureValid records with data 0x100..0x10B, then frameEnd → next cycle dataReady=1 for one cycle, numberOfFeatures=12, frameOverflow=0; reading addresses 0..11 returns 0x100..0x10B one cycle later, address 12 returns 0.
- Next frame: 22 records, with the last record coincident with frameEnd → numberOfFeatures=22; the previous bank is no longer visible and address 21 holds the last record.
- frameEnd with no features → dataReady pulse with numberOfFeatures=0, frameOverflow=0. Two back-to-back frameEnd cycles → two pulses, both count 0.
- 260 records with MAX_FEATURES=256, then frameEnd → numberOfFeatures=256, frameOverflow=1, address 255 holds the 256th record. Following frame with 32 records → numberOfFeatures=32, frameOverflow=0.
- Reset asserted after 5 records mid-frame, then 3 records and frameEnd → no pulse during or after reset until that frameEnd; then numberOfFeatures=3 and bank selection matches the post-reset state.
